// File: rtl/piso_stream_ser_pkg.sv
// Shared types and helpers for the piso_stream_ser serializer.
package piso_stream_ser_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2
  } state_e;

  // Number of serial symbols in one frame.
  function automatic int unsigned frame_len(input int unsigned width, input bit parity_en);
    return width + (parity_en ? 32'd1 : 32'd0);
  endfunction

endpackage

// File: rtl/piso_stream_ser_if.sv
// Load handshake and serial output bundle between a word source and the serializer.
interface piso_stream_ser_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic [WIDTH-1:0] data_i;
  logic             load_valid_i;
  logic             load_ready_o;
  logic             shift_en_i;
  logic             serial_o;
  logic             valid_o;
  logic             last_o;

  modport master (
    output data_i, load_valid_i, shift_en_i,
    input  load_ready_o, serial_o, valid_o, last_o
  );

  modport slave (
    input  data_i, load_valid_i, shift_en_i,
    output load_ready_o, serial_o, valid_o, last_o
  );

endinterface

// File: rtl/piso_bit_cnt.sv
// Down-counter with synchronous load, enable and zero flag; saturates at zero.
module piso_bit_cnt #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/piso_stream_ser.sv
// Parallel-in/serial-out serializer: ready/valid word load, selectable bit order,
// optional trailing parity symbol, shift-enable stalling and gapless back-to-back frames.
module piso_stream_ser
  import piso_stream_ser_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter bit          LSB_FIRST  = 1'b0,
  parameter bit          PARITY_EN  = 1'b1,
  parameter bit          PARITY_ODD = 1'b0
) (
  input logic              clk,
  input logic              rst_n,
  piso_stream_ser_if.slave bus
);

  localparam int unsigned      CNT_W     = $clog2(WIDTH + 1);
  localparam int unsigned      FRAME_LEN = frame_len(WIDTH, PARITY_EN);
  localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(FRAME_LEN - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] shreg_adv;
  logic             par_q, par_d;
  logic             serial_q, serial_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             cnt_load, cnt_en;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             load_ready_c;
  logic             accept_c;

  // Counter holds the number of symbols still to come after the one on serial_o.
  piso_bit_cnt #(.CNT_W(CNT_W)) u_bit_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (CNT_INIT),
    .en_i       (cnt_en),
    .cnt_o      (cnt),
    .zero_c     (cnt_zero)
  );

  assign load_ready_c = (state_q == ST_IDLE) | (last_q & bus.shift_en_i);
  assign accept_c     = bus.load_valid_i & load_ready_c;
  assign shreg_adv    = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    serial_d = serial_q;
    valid_d  = valid_q;
    last_d   = last_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;

    if (accept_c) begin
      // New word: first symbol appears next cycle, parity captured now.
      state_d  = ST_DATA;
      shreg_d  = bus.data_i;
      par_d    = (^bus.data_i) ^ PARITY_ODD;
      serial_d = LSB_FIRST ? bus.data_i[0] : bus.data_i[WIDTH-1];
      valid_d  = 1'b1;
      last_d   = 1'b0;
      cnt_load = 1'b1;
    end else begin
      unique case (state_q)
        ST_DATA, ST_PARITY: begin
          if (bus.shift_en_i) begin
            if (cnt_zero) begin
              state_d  = ST_IDLE;
              serial_d = 1'b0;
              valid_d  = 1'b0;
              last_d   = 1'b0;
            end else begin
              cnt_en = 1'b1;
              last_d = (cnt == CNT_W'(1));
              if (PARITY_EN && (cnt == CNT_W'(1))) begin
                state_d  = ST_PARITY;
                serial_d = par_q;
              end else begin
                shreg_d  = shreg_adv;
                serial_d = LSB_FIRST ? shreg_adv[0] : shreg_adv[WIDTH-1];
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      serial_q <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      par_q    <= par_d;
      serial_q <= serial_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
    end
  end

  assign bus.load_ready_o = load_ready_c;
  assign bus.serial_o     = serial_q;
  assign bus.valid_o      = valid_q;
  assign bus.last_o       = last_q;

endmodule

// File: tb/tb_piso_stream_ser.sv
// Scoreboard bench: three serializer configurations share one stimulus stream and are
// checked symbol by symbol against a word-level frame model.
module tb_piso_stream_ser;

  typedef struct packed {
    logic [2:0] bits;
    logic       last;
  } sym_t;

  // Instance 0: MSB-first even, 1: LSB-first even, 2: LSB-first odd.
  localparam bit [2:0] LSB_CFG = 3'b110;
  localparam bit [2:0] ODD_CFG = 3'b100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data;
  logic       lv;
  logic       shift_en;

  int checks = 0;
  int errors = 0;

  sym_t exp_q[$];

  piso_stream_ser_if #(.WIDTH(8)) if_a ();
  piso_stream_ser_if #(.WIDTH(8)) if_b ();
  piso_stream_ser_if #(.WIDTH(8)) if_c ();

  assign if_a.data_i = data;  assign if_a.load_valid_i = lv;  assign if_a.shift_en_i = shift_en;
  assign if_b.data_i = data;  assign if_b.load_valid_i = lv;  assign if_b.shift_en_i = shift_en;
  assign if_c.data_i = data;  assign if_c.load_valid_i = lv;  assign if_c.shift_en_i = shift_en;

  piso_stream_ser #(.WIDTH(8), .LSB_FIRST(1'b0), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a));
  piso_stream_ser #(.WIDTH(8), .LSB_FIRST(1'b1), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b));
  piso_stream_ser #(.WIDTH(8), .LSB_FIRST(1'b1), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .bus(if_c));

  logic [2:0] v_o, s_o, l_o, r_o;
  assign v_o = {if_c.valid_o,      if_b.valid_o,      if_a.valid_o};
  assign s_o = {if_c.serial_o,     if_b.serial_o,     if_a.serial_o};
  assign l_o = {if_c.last_o,       if_b.last_o,       if_a.last_o};
  assign r_o = {if_c.load_ready_o, if_b.load_ready_o, if_a.load_ready_o};

  always #5 clk = ~clk;

  function automatic void chk(input string name, input int inst, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d at %0t: got %b expected %b", name, inst, $time, act, exp);
    end
  endfunction

  // Expected symbol sequence of one word for every configuration.
  function automatic void push_frame(input logic [7:0] w);
    sym_t s;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 3; i++) s.bits[i] = LSB_CFG[i] ? w[k] : w[7-k];
      s.last = 1'b0;
      exp_q.push_back(s);
    end
    for (int i = 0; i < 3; i++) s.bits[i] = (($countones(w) % 2) == 1) ^ ODD_CFG[i];
    s.last = 1'b1;
    exp_q.push_back(s);
  endfunction

  // Monitor: compare current symbol, then apply the coming edge to the model.
  always @(negedge clk) begin
    sym_t cur;
    logic busy;
    logic rdy;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        chk("rst_valid",  i, v_o[i], 1'b0);
        chk("rst_serial", i, s_o[i], 1'b0);
        chk("rst_last",   i, l_o[i], 1'b0);
      end
      exp_q.delete();
    end else begin
      busy = (exp_q.size() != 0);
      cur  = busy ? exp_q[0] : '0;
      rdy  = !busy || (cur.last && shift_en);
      for (int i = 0; i < 3; i++) begin
        chk("valid",  i, v_o[i], busy);
        chk("serial", i, s_o[i], busy ? cur.bits[i] : 1'b0);
        chk("last",   i, l_o[i], busy ? cur.last : 1'b0);
        chk("ready",  i, r_o[i], rdy);
      end
      if (busy && shift_en) void'(exp_q.pop_front());
      if (lv && rdy) push_frame(data);
    end
  end

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Present a word and keep load_valid_i high until it is taken (bounded).
  task automatic send(input logic [7:0] w);
    logic acc;
    acc  = 1'b0;
    data = w;
    lv   = 1'b1;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      acc = if_a.load_ready_o;
      @(posedge clk);
      #2;
      if (acc) break;
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout word %h: accepted %b expected 1", w, acc);
    end
  endtask

  initial begin
    logic acc;
    rst_n    = 1'b0;
    data     = 8'h00;
    lv       = 1'b0;
    shift_en = 1'b0;
    #10 rst_n = 1'b1;
    step(2);

    // Single frames, continuous shifting.
    shift_en = 1'b1;
    send(8'h8F); lv = 1'b0; step(12);
    send(8'hAA); lv = 1'b0; step(12);

    // Stall after bit 2 for three cycles.
    send(8'hC3); lv = 1'b0; step(3);
    shift_en = 1'b0; step(3);
    shift_en = 1'b1; step(10);

    // Back-to-back frames with load_valid_i held high.
    send(8'h8F); send(8'hAA); lv = 1'b0; step(12);

    // Load request while busy is ignored.
    send(8'h8F); lv = 1'b0; step(3);
    data = 8'hFF; lv = 1'b1; step(2);
    lv = 1'b0; step(10);

    // Reset mid-frame, then a clean frame.
    send(8'h8F); lv = 1'b0; step(4);
    rst_n = 1'b0; step(2);
    rst_n = 1'b1; step(1);
    send(8'hAA); lv = 1'b0; step(12);

    // Randomized traffic with stalls; data held until accepted.
    for (int it = 0; it < 600; it++) begin
      @(negedge clk);
      acc = lv && if_a.load_ready_o;
      @(posedge clk);
      #2;
      shift_en = ($urandom_range(0, 3) != 0);
      if (!lv || acc) begin
        lv   = ($urandom_range(0, 1) == 1);
        data = 8'($urandom);
      end
    end

    // Drain.
    lv = 1'b0; shift_en = 1'b1; step(15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
